// File: rtl/encoder_8to3_reg.sv
// Registered 8-to-3 priority encoder with a sticky pending register,
// a one-deep valid/ready output slot and an accepted-code counter.
module encoder_8to3_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req_in,
    input  logic             load,
    input  logic             ready,
    output logic [2:0]       code_out,
    output logic             valid,
    output logic [7:0]       pending,
    output logic [CNT_W-1:0] acc_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic       slotFree;
    logic       accept;
    logic       hasReq;
    logic       grant;
    logic [2:0] topIdx;
    logic [7:0] clrMask;
    logic [7:0] setMask;
    logic [7:0] pendingNext;

    assign valid    = (state == FULL);
    assign accept   = valid & ready;
    assign slotFree = ~valid | ready;
    assign hasReq   = |pending;
    assign grant    = slotFree & hasReq;

    // Highest set index wins; later iterations overwrite lower ones.
    always_comb begin
        topIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                topIdx = 3'(i);
            end
        end
    end

    // Set is applied after clear so a reload of the granted bit keeps it pending.
    always_comb begin
        clrMask     = grant ? (8'h01 << topIdx) : 8'h00;
        setMask     = load ? req_in : 8'h00;
        pendingNext = (pending & ~clrMask) | setMask;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            EMPTY: begin
                if (grant) begin
                    stateNext = FULL;
                end
            end
            FULL: begin
                if (ready && !hasReq) begin
                    stateNext = EMPTY;
                end
            end
            default: stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 8'h00;
        end else begin
            pending <= pendingNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out <= 3'b000;
        end else if (grant) begin
            code_out <= topIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count <= '0;
        end else if (accept) begin
            acc_count <= acc_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_encoder_8to3_reg.sv
// Bench for encoder_8to3_reg: reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_encoder_8to3_reg;

    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [7:0]    req_in;
    logic          load;
    logic          ready;
    logic [2:0]    code_out;
    logic          valid;
    logic [7:0]    pending;
    logic [CW-1:0] acc_count;

    int nCompared;
    int nMismatched;

    logic [7:0] mPend;
    logic [2:0] mCode;
    logic       mValid;
    int         mAcc;

    encoder_8to3_reg #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .load      (load),
        .ready     (ready),
        .code_out  (code_out),
        .valid     (valid),
        .pending   (pending),
        .acc_count (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan requests highest first, one grant per free slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPend  <= 8'h00;
            mCode  <= 3'd0;
            mValid <= 1'b0;
            mAcc   <= 0;
        end else begin
            automatic logic [7:0] p = mPend;
            automatic int top = -1;
            for (int i = 7; i >= 0; i--) begin
                if (p[i] && top < 0) top = i;
            end
            if (mValid && ready) mAcc <= (mAcc + 1) % (1 << CW);
            if (!mValid || ready) begin
                if (top >= 0) begin
                    mCode  <= 3'(top);
                    mValid <= 1'b1;
                    p[top] = 1'b0;
                end else begin
                    mValid <= 1'b0;
                end
            end
            if (load) p = p | req_in;
            mPend <= p;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model.code", int'(code_out), int'(mCode));
            check("model.valid", int'(valid), int'(mValid));
            check("model.pending", int'(pending), int'(mPend));
            check("model.acc", int'(acc_count), mAcc);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        load  = 1'b0;
        req_in = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        req_in = 8'h00;
        ready  = 1'b0;
        #1;
        check("reset.code", int'(code_out), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.pending", int'(pending), 0);
        check("reset.acc", int'(acc_count), 0);
        step();
        rst_n = 1'b1;

        // single request
        ready = 1'b1; load = 1'b1; req_in = 8'h10;
        step();
        check("single.pend", int'(pending), 8'h10);
        check("single.v0", int'(valid), 0);
        load = 1'b0;
        step();
        check("single.code", int'(code_out), 4);
        check("single.v1", int'(valid), 1);
        step();
        check("single.v2", int'(valid), 0);
        check("single.acc", int'(acc_count), 1);

        // priority drain
        doReset();
        ready = 1'b1; load = 1'b1; req_in = 8'hA5;
        step();
        load = 1'b0;
        step();
        check("drain.c7", int'(code_out), 7);
        check("drain.p25", int'(pending), 8'h25);
        step();
        check("drain.c5", int'(code_out), 5);
        check("drain.p05", int'(pending), 8'h05);
        step();
        check("drain.c2", int'(code_out), 2);
        check("drain.p01", int'(pending), 8'h01);
        step();
        check("drain.c0", int'(code_out), 0);
        check("drain.p00", int'(pending), 8'h00);
        check("drain.v", int'(valid), 1);
        step();
        check("drain.vend", int'(valid), 0);
        check("drain.acc", int'(acc_count), 4);

        // stall
        doReset();
        ready = 1'b0; load = 1'b1; req_in = 8'h03;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall.code", int'(code_out), 1);
            check("stall.valid", int'(valid), 1);
            check("stall.pend", int'(pending), 8'h01);
        end
        ready = 1'b1;
        step();
        check("stall.c0", int'(code_out), 0);
        check("stall.v", int'(valid), 1);
        step();
        check("stall.empty", int'(valid), 0);
        check("stall.acc", int'(acc_count), 2);

        // set wins collision
        doReset();
        ready = 1'b1; load = 1'b1; req_in = 8'h80;
        step();
        step();
        check("coll.pend", int'(pending), 8'h80);
        check("coll.c7a", int'(code_out), 7);
        load = 1'b0;
        step();
        check("coll.c7b", int'(code_out), 7);
        check("coll.v", int'(valid), 1);
        step();
        check("coll.vend", int'(valid), 0);
        check("coll.acc", int'(acc_count), 2);

        // counter wrap: nine accepts on a 3-bit counter
        doReset();
        ready = 1'b1; load = 1'b1; req_in = 8'hFF;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("wrap.acc7", int'(acc_count), 7);
        load = 1'b1; req_in = 8'h01;
        step();
        load = 1'b0;
        check("wrap.acc0", int'(acc_count), 0);
        step();
        step();
        check("wrap.acc1", int'(acc_count), 1);

        // async reset mid-operation
        doReset();
        ready = 1'b0; load = 1'b1; req_in = 8'h0F;
        step();
        step();
        check("areset.pre_v", int'(valid), 1);
        check("areset.pre_p", int'(pending), 8'h0F);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.code", int'(code_out), 0);
        check("areset.valid", int'(valid), 0);
        check("areset.pend", int'(pending), 0);
        check("areset.acc", int'(acc_count), 0);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("areset.idle_v", int'(valid), 0);
            check("areset.idle_p", int'(pending), 0);
        end
        load = 1'b1; req_in = 8'h01;
        step();
        load = 1'b0;
        step();
        check("areset.new_v", int'(valid), 1);
        check("areset.new_c", int'(code_out), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
